alarm_arm_ctrl: RTL and testbench

- Parametrised car-alarm arming controller; successor to the single-door arm/timer pair.
- Supports N doors, separate exit (arming), entry and siren durations, and an explicit state machine.
- Keeps a saturating alarm-event counter.
- Sits between the ignition/door inputs and the siren/status outputs, timed by an external 1 Hz `tick` enable.

---
 rtl/alarm_pkg.sv | 21 ++
 rtl/alarm_countdown.sv | 31 +++
 rtl/alarm_arm_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alarm_arm_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the car-alarm arming controller.
package alarm_pkg;

    localparam int STATE_W = 3;
    localparam int SAT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/alarm_countdown.sv
// Shared down-counter for the arming, entry and siren intervals.
// Priority: reset/clear > load > tick decrement; never goes below zero.
module alarm_countdown #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count  = count_reg;
    assign expire = tick && (count_reg == CNT_W'(1));

endmodule

// File: rtl/alarm_arm_ctrl.sv
// Car-alarm arming controller: DISARMED/ARMING/ARMED/ENTRY/ALARM with a shared countdown.
// Optional arm-confirmation chirp is enabled by defining ALARM_CHIRP_EN.
module alarm_arm_ctrl
    import alarm_pkg::*;
#(
    parameter int N_DOORS = 4,
    parameter int CNT_W   = 4,
    parameter int T_ARM   = 4,
    parameter int T_ENTRY = 6,
    parameter int T_ALARM = 10,
    parameter int EVT_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ignicao,
    input  logic [N_DOORS-1:0] door,
    input  logic               tick,
    output logic               alarme,
    output logic               desarmar,
    output logic               armed,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   count,
    output logic [EVT_W-1:0]   evt_count,
    output logic               chirp
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int EVT_MAX = (1 << EVT_W) - 1;
    localparam logic [CNT_W-1:0] T_ARM_V   = CNT_W'(T_ARM);
    localparam logic [CNT_W-1:0] T_ENTRY_V = CNT_W'(T_ENTRY);
    localparam logic [CNT_W-1:0] T_ALARM_V = CNT_W'(T_ALARM);

    if (N_DOORS < 1 || N_DOORS > 16) begin : g_bad_doors
        $error("alarm_arm_ctrl: N_DOORS must be 1..16");
    end
    if (CNT_W < 1 || CNT_W > 16 || EVT_W < 1 || EVT_W > 16) begin : g_bad_widths
        $error("alarm_arm_ctrl: CNT_W and EVT_W must be 1..16");
    end
    if (T_ARM < 1 || T_ARM > CNT_MAX || T_ENTRY < 1 || T_ENTRY > CNT_MAX ||
        T_ALARM < 1 || T_ALARM > CNT_MAX) begin : g_bad_times
        $error("alarm_arm_ctrl: durations must be 1..2^CNT_W-1");
    end

    state_t           state_reg, state_next;
    logic [EVT_W-1:0] evt_reg;
    logic             alarme_reg, desarmar_reg, armed_reg;
    logic             cnt_load, cnt_clear, cnt_expire, evt_inc;
    logic [CNT_W-1:0] cnt_val, cnt_value;
    logic             any_open;

    assign any_open = |door;

    alarm_countdown #(.CNT_W(CNT_W)) u_countdown (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick),
        .clear    (cnt_clear),
        .count    (cnt_value),
        .expire   (cnt_expire)
    );

    // Ignition beats doors beats tick; a door reload in ARMING overrides a same-cycle tick.
    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_clear  = 1'b0;
        evt_inc    = 1'b0;
        if (ignicao) begin
            state_next = DISARMED;
            cnt_clear  = 1'b1;
        end else begin
            case (state_reg)
                DISARMED: begin
                    if (!any_open) begin
                        state_next = ARMING;
                        cnt_load   = 1'b1;
                        cnt_val    = T_ARM_V;
                    end else begin
                        cnt_clear = 1'b1;
                    end
                end
                ARMING: begin
                    if (any_open) begin
                        cnt_load = 1'b1;
                        cnt_val  = T_ARM_V;
                    end else if (cnt_expire) begin
                        state_next = ARMED;
                        cnt_clear  = 1'b1;
                    end
                end
                ARMED: begin
                    if (any_open) begin
                        state_next = ENTRY;
                        cnt_load   = 1'b1;
                        cnt_val    = T_ENTRY_V;
                    end else begin
                        cnt_clear = 1'b1;
                    end
                end
                ENTRY: begin
                    if (cnt_expire) begin
                        state_next = ALARM;
                        cnt_load   = 1'b1;
                        cnt_val    = T_ALARM_V;
                        evt_inc    = 1'b1;
                    end
                end
                ALARM: begin
                    if (cnt_expire) begin
                        state_next = ARMED;
                        cnt_clear  = 1'b1;
                    end
                end
                default: begin
                    state_next = DISARMED;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= DISARMED;
            evt_reg      <= '0;
            alarme_reg   <= 1'b0;
            desarmar_reg <= 1'b1;
            armed_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            if (evt_inc) begin
                evt_reg <= EVT_W'(sat_inc(SAT_W'(evt_reg), SAT_W'(EVT_MAX)));
            end
            alarme_reg   <= (state_next == ALARM);
            desarmar_reg <= (state_next == DISARMED);
            armed_reg    <= (state_next == ARMED) || (state_next == ENTRY);
        end
    end

`ifdef ALARM_CHIRP_EN
    logic chirp_reg;

    // Set on entering ARMED from ARMING, held through the next tick cycle, dropped on leaving ARMED.
    always_ff @(posedge clock) begin
        if (reset || (state_next != ARMED)) begin
            chirp_reg <= 1'b0;
        end else if (state_reg == ARMING) begin
            chirp_reg <= 1'b1;
        end else if (tick) begin
            chirp_reg <= 1'b0;
        end
    end

    assign chirp = chirp_reg;
`else
    assign chirp = 1'b0;
`endif

    assign alarme    = alarme_reg;
    assign desarmar  = desarmar_reg;
    assign armed     = armed_reg;
    assign state     = state_reg;
    assign count     = cnt_value;
    assign evt_count = evt_reg;

endmodule

// File: tb/tb_alarm_arm_ctrl.sv
// Self-checking bench for alarm_arm_ctrl: directed scenarios plus random stimulus
// checked against a behavioural model of the arming rules.
module tb_alarm_arm_ctrl;

    localparam int N_DOORS = 4;
    localparam int CNT_W   = 4;
    localparam int T_ARM   = 4;
    localparam int T_ENTRY = 6;
    localparam int T_ALARM = 10;
    localparam int EVT_W   = 3;
    localparam int EVT_MAX = (1 << EVT_W) - 1;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ignicao = 1'b0;
    logic [N_DOORS-1:0] door = '0;
    logic               tick = 1'b0;
    logic               alarme, desarmar, armed, chirp;
    logic [2:0]         state;
    logic [CNT_W-1:0]   count;
    logic [EVT_W-1:0]   evt_count;

    int errors = 0;
    int checks = 0;

    // Model: mode 0=disarmed 1=arming 2=armed 3=entry 4=alarm
    int m_state = 0;
    int m_count = 0;
    int m_evt   = 0;
    bit m_chirp = 1'b0;

    always #5 clock = ~clock;

    alarm_arm_ctrl #(
        .N_DOORS (N_DOORS),
        .CNT_W   (CNT_W),
        .T_ARM   (T_ARM),
        .T_ENTRY (T_ENTRY),
        .T_ALARM (T_ALARM),
        .EVT_W   (EVT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ignicao   (ignicao),
        .door      (door),
        .tick      (tick),
        .alarme    (alarme),
        .desarmar  (desarmar),
        .armed     (armed),
        .state     (state),
        .count     (count),
        .evt_count (evt_count),
        .chirp     (chirp)
    );

    function automatic logic [13:0] dut_vec();
        return {state, count, evt_count, alarme, desarmar, armed, chirp};
    endfunction

    function automatic logic [13:0] mdl_vec();
        return {3'(m_state), 4'(m_count), 3'(m_evt), m_state == 4, m_state == 0,
                (m_state == 2) || (m_state == 3), m_chirp};
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle 1 time unit.
    task automatic step(input bit rst, input bit ign, input logic [N_DOORS-1:0] d, input bit t);
        int ns, nc;
        bit open, exp_t, nchirp;
        reset = rst; ignicao = ign; door = d; tick = t;
        @(posedge clock);
        ns = m_state; nc = m_count; nchirp = 1'b0;
        if (rst) begin
            ns = 0; nc = 0; m_evt = 0;
        end else begin
            open  = (d != '0);
            exp_t = t && (m_count == 1);
            if (ign) begin
                ns = 0; nc = 0;
            end else begin
                case (m_state)
                    0: if (!open) begin ns = 1; nc = T_ARM; end else nc = 0;
                    1: if (open) nc = T_ARM;
                       else if (exp_t) begin ns = 2; nc = 0; end
                       else if (t) nc = m_count - 1;
                    2: if (open) begin ns = 3; nc = T_ENTRY; end
                    3: if (exp_t) begin
                           ns = 4; nc = T_ALARM;
                           if (m_evt < EVT_MAX) m_evt = m_evt + 1;
                       end else if (t) nc = m_count - 1;
                    4: if (exp_t) begin ns = 2; nc = 0; end
                       else if (t) nc = m_count - 1;
                    default: begin ns = 0; nc = 0; end
                endcase
            end
`ifdef ALARM_CHIRP_EN
            if (ns == 2) nchirp = (m_state == 1) ? 1'b1 : (m_chirp && !t);
`endif
        end
        m_state = ns; m_count = nc; m_chirp = nchirp;
        #1;
        $display("tx t=%0t rst=%0b ign=%0b door=%b tick=%0b -> state=%0d count=%0d evt=%0d alarme=%0b chirp=%0b",
                 $time, rst, ign, d, t, state, count, evt_count, alarme, chirp);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (dut_vec() !== 14'b000_0000_000_0_1_0_0) begin
            errors++;
            $display("FAIL reset_values: got %b required %b", dut_vec(), 14'b000_0000_000_0_1_0_0);
        end
    endtask

    task automatic test_arming();
        step(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (state !== 3'd1 || count !== 4'd4) begin
            errors++;
            $display("FAIL arming_load: got state=%0d count=%0d required state=1 count=4", state, count);
        end
        for (int i = 1; i <= 24; i++) begin
            step(1'b0, 1'b0, '0, (i % 4) == 0);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL arming_seq i=%0d: got %b required %b", i, dut_vec(), mdl_vec());
            end
            if (i == 16) begin
                checks++;
`ifdef ALARM_CHIRP_EN
                if (state !== 3'd2 || chirp !== 1'b1) begin
`else
                if (state !== 3'd2 || chirp !== 1'b0) begin
`endif
                    errors++;
                    $display("FAIL armed_after_t_arm: got state=%0d chirp=%0b", state, chirp);
                end
            end
        end
        checks++;
        if (state !== 3'd2 || armed !== 1'b1 || chirp !== 1'b0) begin
            errors++;
            $display("FAIL armed_steady: got state=%0d armed=%0b chirp=%0b required 2/1/0", state, armed, chirp);
        end
    endtask

    task automatic test_reload();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL reload_pre: got count=%0d required 2", count);
        end
        step(1'b0, 1'b0, 4'b1000, 1'b1);
        checks++;
        if (state !== 3'd1 || count !== 4'd4 || dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reload_wins: got state=%0d count=%0d required state=1 count=4", state, count);
        end
    endtask

    task automatic test_entry();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < T_ARM; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 4'b0001, 1'b0);
        checks++;
        if (state !== 3'd3 || count !== 4'd6 || armed !== 1'b1) begin
            errors++;
            $display("FAIL entry_start: got state=%0d count=%0d required state=3 count=6", state, count);
        end
        for (int i = 1; i <= T_ENTRY; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            step(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL entry_tick %0d: got %b required %b", i, dut_vec(), mdl_vec());
            end
            if (i == T_ENTRY - 1) begin
                checks++;
                if (state !== 3'd3 || count !== 4'd1 || alarme !== 1'b0) begin
                    errors++;
                    $display("FAIL entry_last: got state=%0d count=%0d alarme=%0b", state, count, alarme);
                end
            end
        end
        checks++;
        if (state !== 3'd4 || alarme !== 1'b1 || count !== 4'd10 || evt_count !== 3'd1) begin
            errors++;
            $display("FAIL siren_on: got state=%0d alarme=%0b count=%0d evt=%0d required 4/1/10/1",
                     state, alarme, count, evt_count);
        end
    endtask

    task automatic test_disarm_in_alarm();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (count !== 4'd5 || state !== 3'd4) begin
            errors++;
            $display("FAIL alarm_count5: got state=%0d count=%0d required 4/5", state, count);
        end
        step(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (state !== 3'd0 || alarme !== 1'b0 || desarmar !== 1'b1 || evt_count !== 3'd1 || count !== 4'd0) begin
            errors++;
            $display("FAIL ign_disarm: got state=%0d alarme=%0b desarmar=%0b evt=%0d count=%0d",
                     state, alarme, desarmar, evt_count, count);
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int ep = 1; ep <= 10; ep++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            for (int i = 0; i < T_ARM; i++) step(1'b0, 1'b0, '0, 1'b1);
            step(1'b0, 1'b0, 4'b0010, 1'b0);
            for (int i = 0; i < T_ENTRY; i++) step(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (evt_count !== 3'((ep > EVT_MAX) ? EVT_MAX : ep) || state !== 3'd4) begin
                errors++;
                $display("FAIL evt_episode %0d: got evt=%0d state=%0d", ep, evt_count, state);
            end
            if (ep < 10) step(1'b0, 1'b1, '0, 1'b0);
        end
        for (int i = 0; i < T_ALARM - 1; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 4'b0100, 1'b1);
        checks++;
        if (state !== 3'd2 || alarme !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL alarm_expiry: got state=%0d alarme=%0b count=%0d required 2/0/0", state, alarme, count);
        end
        step(1'b0, 1'b0, 4'b0100, 1'b0);
        checks++;
        if (state !== 3'd3 || count !== 4'd6 || evt_count !== 3'd7) begin
            errors++;
            $display("FAIL reentry: got state=%0d count=%0d evt=%0d required 3/6/7", state, count, evt_count);
        end
    endtask

    task automatic test_reset_mid_entry();
        step(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (state !== 3'd3 || count !== 4'd5) begin
            errors++;
            $display("FAIL mid_entry_pre: got state=%0d count=%0d required 3/5", state, count);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (dut_vec() !== 14'b000_0000_000_0_1_0_0) begin
            errors++;
            $display("FAIL reset_mid_entry: got %b required %b", dut_vec(), 14'b000_0000_000_0_1_0_0);
        end
    endtask

    task automatic test_random();
        bit rst, ign, t;
        logic [N_DOORS-1:0] d;
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 1200; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            ign = ($urandom_range(0, 39) == 0);
            d   = ($urandom_range(0, 7) == 0) ? N_DOORS'($urandom) : '0;
            t   = ($urandom_range(0, 2) == 0);
            step(rst, ign, d, t);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b required %b", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_reload();
        test_entry();
        test_disarm_in_alarm();
        test_saturation();
        test_reset_mid_entry();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
